bufgmux_switch_ctrl: RTL and testbench
======================================

// Module: bufgmux_switch_ctrl
//
// PURPOSE
//  Sequencer for a two-input global clock mux (I0/I1/S). Runs on a free-running
//  control clock. Accepts switch requests, or fails over automatically when the
//  active source dies, and drives the mux select S with a gated, timed sequence:
//  qualify target -> gate downstream -> flip S -> settle -> ungate.
//  The block sits between the clock-monitor logic (CLK0_OK/CLK1_OK) and the mux.
//
// PARAMETERS
//  INIT_SEL       0    value of S after reset (0=I0, 1=I1)
//  HOLD_CYC       4    cycles CE_OUT is held low before S changes (>=1)
//  SETTLE_CYC     8    cycles CE_OUT stays low after S changes (>=1)
//  TIMEOUT_CYC    256  max cycles to wait for target OK in QUALIFY (>=1)
//  AUTO_FAILOVER  1    1: enable autonomous switch-away from a dead source
//  CNT_W          9    counter width; must hold max(HOLD,SETTLE,TIMEOUT)_CYC
//
// PORTS
//  CLK       in   1  control clock, free-running, independent of I0/I1
//  RST       in   1  synchronous reset, active-high
//  REQ       in   1  switch request; held high until ACK
//  REQ_SEL   in   1  requested select value, stable while REQ high
//  CLK0_OK   in   1  I0 source alive (already synchronised to CLK)
//  CLK1_OK   in   1  I1 source alive (already synchronised to CLK)
//  S         out  1  mux select, registered
//  CE_OUT    out  1  downstream clock-enable; 0 while switching
//  BUSY      out  1  1 in every state except IDLE
//  ACK       out  1  1-cycle pulse: request or failover finished
//  ERR       out  1  1-cycle pulse with ACK: target never qualified, S unchanged
//  FAIL_EVT  out  1  1-cycle pulse with ACK: completed sequence was a failover
//
// BEHAVIOUR
//  - All outputs are registered or Moore-decoded from registered state.
//  - Reset: S=INIT_SEL, CE_OUT=0, BUSY=1, ACK=ERR=FAIL_EVT=0, state=STARTUP,
//    counter=0. RST asserted in any state aborts it immediately, with no ACK.
//  - STARTUP: CE_OUT=0 for SETTLE_CYC cycles, then IDLE.
//  - IDLE: CE_OUT=1, BUSY=0. Priority, evaluated each cycle:
//    1) AUTO_FAILOVER && current-source OK==0 && other OK==1: tgt=~S,
//       fo=1 -> GATE. A concurrent REQ is not acknowledged and is taken later.
//    2) REQ && REQ_SEL==S -> DONE (no-op, ACK only).
//    3) REQ && REQ_SEL!=S: tgt=REQ_SEL, fo=0 -> QUALIFY.
//  - QUALIFY: CE_OUT=1. Target OK==1 -> GATE. After TIMEOUT_CYC cycles without
//    OK -> DONE with err=1. S and CE_OUT are never disturbed on this path.
//  - GATE: CE_OUT=0 for HOLD_CYC cycles -> SWITCH.
//  - SWITCH: one cycle; S<=tgt on exit -> SETTLE.
//  - SETTLE: CE_OUT=0 for SETTLE_CYC cycles -> DONE.
//  - DONE: one cycle. CE_OUT=1, ACK=1, ERR=err, FAIL_EVT=fo. Clear err/fo -> IDLE.
//  - Timing, counted from the edge that samples REQ in IDLE (cycle 0), target OK
//    already high: QUALIFY=1; CE_OUT=0 over cycles 2..2+HOLD+SETTLE; new S from
//    cycle 3+HOLD; ACK at cycle 3+HOLD+SETTLE (15 with defaults).
//  - A failover starts GATE at cycle 1, so every step is one cycle earlier.
//  - An OK drop after QUALIFY does not abort the sequence. It always completes,
//    and IDLE failover handles the drop afterwards.
//  - Both OK low in IDLE: no action, S is held.
//  - Requester must drop REQ the cycle after ACK. If REQ is still high, it is
//    re-evaluated as a new request.
//  - Counters saturate/reload per state. No wrap-around in any state.
//
// TESTING
//  1 Reset, defaults -> S=0, CE_OUT=0 for 8 cycles, then CE_OUT=1, BUSY=0.
//  2 REQ=1 REQ_SEL=1, CLK1_OK=1 -> CE_OUT low cycles 2..14, S=1 at 7,
//    ACK at 15, ERR=0.
//  3 REQ_SEL=1 with CLK1_OK=0 -> ACK+ERR at cycle 258 (QUALIFY 1..257),
//    S=0, CE_OUT never low.
//  4 S=0, drop CLK0_OK, CLK1_OK=1 -> S=1 at cycle 6, ACK+FAIL_EVT at 14.
//  5 REQ_SEL==S -> ACK at cycle 1 only, no CE_OUT dip. REQ concurrent with
//    failover -> failover first, then REQ serviced.
//  6 RST during SETTLE -> next cycle S=INIT_SEL, CE_OUT=0, no ACK;
//    STARTUP repeats.

Source files
------------

// File: rtl/bufgmux_switch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bufgmux_switch_ctrl
// Description : Sequencer for a two-input global clock mux. Accepts switch
//               requests or fails over away from a dead source, and drives
//               the mux select with a gated sequence:
//               qualify target -> gate downstream -> flip S -> settle -> ungate.
// Revision    : 1.0  initial release
// ============================================================================
module bufgmux_switch_ctrl #(
  parameter bit INIT_SEL      = 1'b0,
  parameter int HOLD_CYC      = 4,
  parameter int SETTLE_CYC    = 8,
  parameter int TIMEOUT_CYC   = 256,
  parameter bit AUTO_FAILOVER = 1'b1,
  parameter int CNT_W         = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic req_sel,
  input  logic clk0_ok,
  input  logic clk1_ok,
  output logic s,
  output logic ce_out,
  output logic busy,
  output logic ack,
  output logic err,
  output logic fail_evt
);

  // Sequencer states; explicit encoding keeps the register width fixed.
  typedef enum logic [2:0] {
    ST_STARTUP = 3'd0,
    ST_IDLE    = 3'd1,
    ST_QUALIFY = 3'd2,
    ST_GATE    = 3'd3,
    ST_SWITCH  = 3'd4,
    ST_SETTLE  = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  // Terminal counts. GATE/SETTLE/STARTUP count 0..N-1 so they last exactly N
  // cycles; QUALIFY gives up once it has waited the full timeout window.
  localparam logic [CNT_W-1:0] c_hold_last   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] c_settle_last = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] c_timeout     = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] c_cnt_one     = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_tgt;      // select value the running sequence moves to
  logic             r_fo_flag;  // running sequence was started by failover

  // Registered outputs
  logic r_s;
  logic r_ce_out;
  logic r_busy;
  logic r_ack;
  logic r_err;
  logic r_fail_evt;

  // Health of the currently selected source, the other one, and the target.
  logic w_cur_ok;
  logic w_oth_ok;
  logic w_tgt_ok;
  logic w_failover;

  // Source health decode relative to the present select and pending target.
  always_comb begin
    w_cur_ok   = r_s   ? clk1_ok : clk0_ok;
    w_oth_ok   = r_s   ? clk0_ok : clk1_ok;
    w_tgt_ok   = r_tgt ? clk1_ok : clk0_ok;
    // Only leave a dead source when the alternative is alive; with both dead
    // there is nothing better to switch to, so S is held.
    w_failover = AUTO_FAILOVER && !w_cur_ok && w_oth_ok;
  end

  // Sequencer: state, counter and all registered outputs in one process.
  // Outputs are assigned on the transition into each state so that they
  // always reflect the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_STARTUP;
      r_cnt      <= '0;
      r_tgt      <= INIT_SEL;
      r_fo_flag  <= 1'b0;
      r_s        <= INIT_SEL;
      r_ce_out   <= 1'b0;
      r_busy     <= 1'b1;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_fail_evt <= 1'b0;
    end else begin
      // Status pulses last exactly one cycle unless re-armed below.
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_fail_evt <= 1'b0;

      case (r_state)
        // Hold downstream gated while the selected clock settles after reset.
        ST_STARTUP: begin
          if (r_cnt == c_settle_last) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_ce_out <= 1'b1;
            r_busy   <= 1'b0;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end

        // Failover has priority over a pending request; the request stays
        // pending and is taken once the failover sequence has finished.
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_failover) begin
            r_tgt     <= ~r_s;
            r_fo_flag <= 1'b1;
            r_state   <= ST_GATE;
            r_ce_out  <= 1'b0;
            r_busy    <= 1'b1;
          end else if (req && (req_sel == r_s)) begin
            // Already on the requested source: acknowledge without switching.
            r_state <= ST_DONE;
            r_busy  <= 1'b1;
            r_ack   <= 1'b1;
          end else if (req) begin
            r_tgt     <= req_sel;
            r_fo_flag <= 1'b0;
            r_state   <= ST_QUALIFY;
            r_busy    <= 1'b1;
          end
        end

        // Wait for the target source to be alive before touching anything
        // downstream; a timeout ends the request with S and CE untouched.
        ST_QUALIFY: begin
          if (w_tgt_ok) begin
            r_state  <= ST_GATE;
            r_cnt    <= '0;
            r_ce_out <= 1'b0;
          end else if (r_cnt == c_timeout) begin
            r_state <= ST_DONE;
            r_cnt   <= '0;
            r_ack   <= 1'b1;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end

        // Downstream is gated; give it HOLD_CYC cycles before the select moves.
        ST_GATE: begin
          if (r_cnt == c_hold_last) begin
            r_state <= ST_SWITCH;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end

        // Single cycle in which the mux select is flipped.
        ST_SWITCH: begin
          r_s     <= r_tgt;
          r_state <= ST_SETTLE;
          r_cnt   <= '0;
        end

        // Keep downstream gated while the mux output settles on the new input.
        ST_SETTLE: begin
          if (r_cnt == c_settle_last) begin
            r_state    <= ST_DONE;
            r_cnt      <= '0;
            r_ce_out   <= 1'b1;
            r_ack      <= 1'b1;
            r_fail_evt <= r_fo_flag;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end

        // Completion cycle: pulses are already on the outputs; return to IDLE.
        ST_DONE: begin
          r_state   <= ST_IDLE;
          r_cnt     <= '0;
          r_fo_flag <= 1'b0;
          r_ce_out  <= 1'b1;
          r_busy    <= 1'b0;
        end

        // Unreachable encodings recover through the startup gating sequence.
        default: begin
          r_state  <= ST_STARTUP;
          r_cnt    <= '0;
          r_ce_out <= 1'b0;
          r_busy   <= 1'b1;
        end
      endcase
    end
  end

  assign s        = r_s;
  assign ce_out   = r_ce_out;
  assign busy     = r_busy;
  assign ack      = r_ack;
  assign err      = r_err;
  assign fail_evt = r_fail_evt;

endmodule
`default_nettype wire

// File: tb/tb_bufgmux_switch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bufgmux_switch_ctrl
// Description : Self-checking bench for bufgmux_switch_ctrl: vector table for
//               reset/idle behaviour, hand sequences for reset-abort and
//               failover-versus-request ordering, and random transactions
//               compared against a timeline model of each sequence.
// Revision    : 1.0  initial release
// ============================================================================
module tb_bufgmux_switch_ctrl;

  localparam int c_hold    = 4;
  localparam int c_settle  = 8;
  localparam int c_timeout = 256;

  localparam int c_k_noop = 0;  // request for the already-selected source
  localparam int c_k_sw   = 1;  // request, target alive
  localparam int c_k_to   = 2;  // request, target never alive
  localparam int c_k_fo   = 3;  // autonomous failover

  logic clk = 1'b0;
  logic rst;
  logic req;
  logic req_sel;
  logic clk0_ok;
  logic clk1_ok;
  logic s;
  logic ce_out;
  logic busy;
  logic ack;
  logic err;
  logic fail_evt;
  logic [5:0] obs;

  int n_pass  = 0;
  int n_total = 0;

  bufgmux_switch_ctrl #(
    .INIT_SEL      (1'b0),
    .HOLD_CYC      (c_hold),
    .SETTLE_CYC    (c_settle),
    .TIMEOUT_CYC   (c_timeout),
    .AUTO_FAILOVER (1'b1),
    .CNT_W         (9)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_sel  (req_sel),
    .clk0_ok  (clk0_ok),
    .clk1_ok  (clk1_ok),
    .s        (s),
    .ce_out   (ce_out),
    .busy     (busy),
    .ack      (ack),
    .err      (err),
    .fail_evt (fail_evt)
  );

  always #5 clk = ~clk;

  assign obs = {s, ce_out, busy, ack, err, fail_evt};

  typedef struct {
    logic       rst;
    logic       req;
    logic       req_sel;
    logic       ok0;
    logic       ok1;
    logic [5:0] exp;  // {s, ce_out, busy, ack, err, fail_evt}
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mkv(logic r, logic q, logic qs, logic o0, logic o1,
                               logic [5:0] e);
    vec_t v;
    v.rst = r; v.req = q; v.req_sel = qs; v.ok0 = o0; v.ok1 = o1; v.exp = e;
    return v;
  endfunction

  // Cycle on which ACK appears, counted from the edge that starts the sequence.
  function automatic int ack_cycle(int kind);
    case (kind)
      c_k_noop: return 1;
      c_k_sw:   return 2 + c_hold + c_settle + 1;
      c_k_fo:   return 1 + c_hold + c_settle + 1;
      default:  return c_timeout + 2;
    endcase
  endfunction

  // Expected outputs on cycle k of a sequence that started with select s0.
  function automatic logic [5:0] model(int kind, logic s0, int k);
    int   g;
    int   ac;
    logic sv;
    logic ce;
    logic ak;
    logic moves;
    moves = (kind == c_k_sw) || (kind == c_k_fo);
    g     = (kind == c_k_fo) ? 1 : 2;
    ac    = ack_cycle(kind);
    if (k > ac) begin
      sv = moves ? ~s0 : s0;
      return {sv, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    end
    sv = s0;
    ce = 1'b1;
    if (moves) begin
      if (k >= g + c_hold + 1) sv = ~s0;
      if (k >= g && k <= g + c_hold + c_settle) ce = 1'b0;
    end
    ak = (k == ac);
    return {sv, ce, 1'b1, ak, ak && (kind == c_k_to), ak && (kind == c_k_fo)};
  endfunction

  task automatic chk_vec(input string name, input logic [5:0] got,
                         input logic [5:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got {s,ce,busy,ack,err,fail}=%b expected %b",
                  name, got, exp);
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic       cur_s;
    logic [5:0] fin;
    int         kind;
    int         ac;
    int         r;
    int         n_ack;
    int         a1;
    int         a2;
    logic       f1;
    logic       f2;
    logic       e2;

    rst = 1'b1; req = 1'b0; req_sel = 1'b0; clk0_ok = 1'b1; clk1_ok = 1'b1;

    // Reset, startup gating, no-op request, both sources dead in IDLE.
    tbl[0] = mkv(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6'b001000);
    for (int i = 1; i < 8; i++)
      tbl[i] = mkv(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'b001000);
    tbl[8]  = mkv(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'b010000);
    tbl[9]  = mkv(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 6'b011100);
    tbl[10] = mkv(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'b010000);
    tbl[11] = mkv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b010000);
    tbl[12] = mkv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b010000);
    tbl[13] = mkv(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'b010000);

    @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      rst = tbl[i].rst; req = tbl[i].req; req_sel = tbl[i].req_sel;
      clk0_ok = tbl[i].ok0; clk1_ok = tbl[i].ok1;
      step();
      chk_vec($sformatf("tbl%0d", i), obs, tbl[i].exp);
    end

    // Switch to I1, then reset while the mux output is settling.
    req = 1'b1; req_sel = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      chk_vec($sformatf("pre_rst_k%0d", k), obs, model(c_k_sw, 1'b0, k));
    end
    rst = 1'b1; req = 1'b0;
    step();
    chk_vec("rst_in_settle", obs, 6'b001000);
    rst = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      step();
      chk_vec($sformatf("restartup_j%0d", j), obs,
              (j < 8) ? 6'b001000 : 6'b010000);
    end

    // Failover and a request raised together: failover is acknowledged
    // first, the still-pending request is serviced afterwards.
    clk0_ok = 1'b0; clk1_ok = 1'b1; req = 1'b1; req_sel = 1'b0;
    n_ack = 0; a1 = -1; a2 = -1; f1 = 1'b0; f2 = 1'b1; e2 = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (ack) begin
        n_ack++;
        if (n_ack == 1) begin
          a1 = k; f1 = fail_evt; clk0_ok = 1'b1;
        end else if (n_ack == 2) begin
          a2 = k; f2 = fail_evt; e2 = err; req = 1'b0;
        end
      end
    end
    chk_int("fo_ack_cycle",  a1, 14);
    chk_int("fo_fail_evt",   int'(f1), 1);
    chk_int("req_ack_cycle", a2, 30);
    chk_int("req_fail_evt",  int'(f2), 0);
    chk_int("req_err",       int'(e2), 0);
    chk_int("ack_count",     n_ack, 2);
    chk_int("final_s",       int'(s), 0);
    req = 1'b0; clk0_ok = 1'b1; clk1_ok = 1'b1;

    // Random transactions against the timeline model.
    cur_s = s;
    for (int t = 0; t < 24; t++) begin
      r = int'($urandom_range(0, 9));
      kind = (r < 2) ? c_k_noop : (r < 6) ? c_k_sw : (r < 7) ? c_k_to : c_k_fo;
      case (kind)
        c_k_noop: begin req = 1'b1; req_sel = cur_s; end
        c_k_sw:   begin req = 1'b1; req_sel = ~cur_s; end
        c_k_to: begin
          req = 1'b1; req_sel = ~cur_s;
          if (cur_s) clk0_ok = 1'b0; else clk1_ok = 1'b0;
        end
        default: begin
          req = 1'b0;
          clk0_ok = cur_s; clk1_ok = ~cur_s;
        end
      endcase
      ac = ack_cycle(kind);
      for (int k = 1; k <= ac + 1; k++) begin
        step();
        chk_vec($sformatf("rand%0d_kind%0d_k%0d", t, kind, k), obs,
                model(kind, cur_s, k));
        if (k == ac) begin
          req = 1'b0; clk0_ok = 1'b1; clk1_ok = 1'b1;
        end else if (k < ac && ((kind == c_k_sw && k >= 2) ||
                                (kind == c_k_fo && k >= 1))) begin
          // Source health may flap once the sequence is committed.
          clk0_ok = 1'($urandom_range(0, 1));
          clk1_ok = 1'($urandom_range(0, 1));
        end
      end
      fin = model(kind, cur_s, ac + 1);
      cur_s = fin[5];
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
